// File: rtl/write_buffer.sv
// Posted-write buffer between a cache controller and main memory.
// Writes are queued in a DEPTH-entry FIFO and acknowledged the next cycle;
// reads forward from the newest matching queued write, otherwise go to memory
// ahead of any queued writes.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   up_req/up_we/up_addr/up_wdata   upstream request
//   up_ready, up_done, up_rdata     upstream accept, completion pulse, read data
//   mem_req/mem_we/mem_addr/mem_wdata  memory request (one-cycle, combinational)
//   mem_ready, mem_done, mem_rdata  memory idle flag, completion pulse, read data
//   wb_empty                        no queued writes and no pending read
module write_buffer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_req,
    input  logic              up_we,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic [DATA_W-1:0] up_wdata,
    output logic              up_ready,
    output logic              up_done,
    output logic [DATA_W-1:0] up_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_addr [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic                r_rd_pend;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_done;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_accept;
    logic                w_push;
    logic                w_rd;
    logic                w_hit;
    logic [DATA_W-1:0]   w_hit_data;
    logic [PTR_W-1:0]    w_idx;
    logic                w_pop;
    logic                w_rd_done;

    assign up_ready = !rst && !r_rd_pend && (r_count < CNT_W'(DEPTH));
    assign w_accept = up_req && up_ready;
    assign w_push   = w_accept && up_we;
    assign w_rd     = w_accept && !up_we;
    assign wb_empty = rst || ((r_count == '0) && !r_rd_pend);

    // Read forwarding: walk oldest to newest so the newest match wins.
    // The head being drained is still valid here, so a read that lands in
    // the same cycle as its pop still forwards.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == up_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_idx];
            end
        end
    end

    // Memory FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory FSM next state and request port; a pending read beats queued writes.
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        w_pop       = 1'b0;
        w_rd_done   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (mem_ready && r_rd_pend) begin
                        mem_req     = 1'b1;
                        mem_addr    = r_rd_addr;
                        w_state_nxt = S_RD;
                    end else if (mem_ready && (r_count != '0)) begin
                        mem_req     = 1'b1;
                        mem_we      = 1'b1;
                        mem_addr    = r_addr[r_head];
                        mem_wdata   = r_data[r_head];
                        w_state_nxt = S_WR;
                    end
                end
                S_WR: begin
                    if (mem_done) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_RD: begin
                    if (mem_done) begin
                        w_rd_done   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A memory read completes combinationally; posted writes and hits are one cycle late.
    assign up_done = !rst && (r_done || w_rd_done);

    always_comb begin
        up_rdata = '0;
        if (!rst) begin
            if (w_rd_done) begin
                up_rdata = mem_rdata;
            end else if (r_done) begin
                up_rdata = r_rdata;
            end
        end
    end

    // FIFO payload storage; contents are qualified by r_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= up_addr;
            r_data[r_tail] <= up_wdata;
        end
    end

    // FIFO bookkeeping, pending-read tracking and upstream completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_valid   <= '0;
            r_rd_pend <= 1'b0;
            r_rd_addr <= '0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_done  <= w_push || (w_rd && w_hit);
            r_rdata <= (w_rd && w_hit) ? w_hit_data : '0;
            if (w_push) begin
                r_tail          <= r_tail + PTR_W'(1);
                r_valid[r_tail] <= 1'b1;
            end
            if (w_pop) begin
                r_head          <= r_head + PTR_W'(1);
                r_valid[r_head] <= 1'b0;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_rd && !w_hit) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= up_addr;
            end else if (w_rd_done) begin
                r_rd_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based behavioural model.
module tb_write_buffer;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          up_req, up_we;
    logic [AW-1:0] up_addr;
    logic [DW-1:0] up_wdata;
    logic          up_ready, up_done;
    logic [DW-1:0] up_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready, mem_done;
    logic [DW-1:0] mem_rdata;
    logic          wb_empty;

    always #5 clk = ~clk;

    write_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .up_req(up_req), .up_we(up_we), .up_addr(up_addr), .up_wdata(up_wdata),
        .up_ready(up_ready), .up_done(up_done), .up_rdata(up_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .wb_empty(wb_empty)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model: queued writes, pending read, outstanding memory op (0 none, 1 write, 2 read).
    ent_t          m_q[$];
    bit            m_pend = 1'b0;
    logic [AW-1:0] m_paddr = '0;
    int            m_out = 0;
    bit            m_done_nx = 1'b0;
    bit            m_hit_nx = 1'b0;
    logic [DW-1:0] m_rdata_nx = '0;

    // Memory responder state.
    bit auto_mem = 1'b0;
    bit stray_en = 1'b0;
    bit rsp_busy = 1'b0;
    int rsp_lat  = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs already applied; checks, advances model, waits one cycle.
    task automatic step();
        bit            e_ready, e_issue, e_we, e_rdcomp, e_done, e_empty;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        bit            acc, hit, nxt_done;
        logic [DW-1:0] hd;
        #1;
        e_ready  = !rst && !m_pend && (m_q.size() < DEPTH);
        e_issue  = !rst && (m_out == 0) && mem_ready && (m_pend || m_q.size() > 0);
        e_we     = e_issue && !m_pend;
        e_addr   = !e_issue ? '0 : (m_pend ? m_paddr : m_q[0].a);
        e_wdata  = e_we ? m_q[0].d : '0;
        e_rdcomp = !rst && (m_out == 2) && mem_done;
        e_done   = !rst && (m_done_nx || e_rdcomp);
        e_empty  = rst || (m_q.size() == 0 && !m_pend);

        chk("up_ready", 32'(up_ready), 32'(e_ready));
        chk("up_done",  32'(up_done),  32'(e_done));
        chk("mem_req",  32'(mem_req),  32'(e_issue));
        chk("mem_we",   32'(mem_we),   32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (!e_issue || e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        chk("wb_empty", 32'(wb_empty), 32'(e_empty));
        if (rst)                        chk("up_rdata_rst", 32'(up_rdata), 32'h0);
        else if (e_rdcomp)              chk("up_rdata_mem", 32'(up_rdata), 32'(mem_rdata));
        else if (m_done_nx && m_hit_nx) chk("up_rdata_fwd", 32'(up_rdata), 32'(m_rdata_nx));

        nxt_done = 1'b0;
        if (rst) begin
            m_q.delete();
            m_pend    = 1'b0;
            m_out     = 0;
            m_done_nx = 1'b0;
            m_hit_nx  = 1'b0;
            rsp_busy  = 1'b0;
        end else begin
            acc = up_req && e_ready;
            hit = 1'b0;
            hd  = '0;
            if (acc && !up_we) begin
                for (int i = m_q.size() - 1; i >= 0; i--) begin
                    if (m_q[i].a == up_addr) begin
                        hit = 1'b1;
                        hd  = m_q[i].d;
                        break;
                    end
                end
                if (!hit) begin
                    m_pend  = 1'b1;
                    m_paddr = up_addr;
                end
            end
            if (m_out == 1 && mem_done) begin
                void'(m_q.pop_front());
                m_out = 0;
            end else if (m_out == 2 && mem_done) begin
                m_pend = 1'b0;
                m_out  = 0;
            end else if (e_issue) begin
                m_out = e_we ? 1 : 2;
            end
            if (acc && up_we) m_q.push_back('{a: up_addr, d: up_wdata});
            m_done_nx  = acc && (up_we || hit);
            m_hit_nx   = acc && !up_we && hit;
            m_rdata_nx = hd;

            if (rsp_busy) begin
                if (rsp_lat == 0) begin
                    nxt_done = 1'b1;
                    rsp_busy = 1'b0;
                end else begin
                    rsp_lat--;
                end
            end else if (e_issue) begin
                rsp_lat = int'($urandom_range(0, 3));
                if (rsp_lat == 0) nxt_done = 1'b1;
                else begin
                    rsp_busy = 1'b1;
                    rsp_lat--;
                end
            end else if (stray_en && $urandom_range(0, 12) == 0) begin
                nxt_done = 1'b1;
            end
        end
        @(negedge clk);
        if (auto_mem) begin
            mem_done  = nxt_done;
            mem_rdata = $urandom;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        up_req = 1'b1; up_we = 1'b1; up_addr = a; up_wdata = d;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        up_req = 1'b1; up_we = 1'b0; up_addr = a; up_wdata = '0;
    endtask

    task automatic drain(input int max);
        int n = 0;
        auto_mem = 1'b1; mem_ready = 1'b1; up_req = 1'b0;
        while ((m_q.size() != 0 || m_pend || m_out != 0 || rsp_busy) && n < max) begin
            step();
            n++;
        end
        chk("drain_in_budget", 32'(n < max), 32'h1);
        auto_mem = 1'b0; mem_ready = 1'b0; mem_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; up_req = 1'b0; up_we = 1'b0; up_addr = '0; up_wdata = '0;
        mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        @(negedge clk);
        #1;
        chk("rst_up_ready", 32'(up_ready), 32'h0);
        chk("rst_wb_empty", 32'(wb_empty), 32'h1);
        step();
        step();

        // Single posted write then drain.
        rst = 1'b0; mem_ready = 1'b1;
        wr(16'h0040, 32'hDEADBEEF);
        #1 chk("rel_up_ready", 32'(up_ready), 32'h1);
        step();
        up_req = 1'b0;
        #1;
        chk("w1_done", 32'(up_done), 32'h1);
        chk("w1_mem_req", 32'(mem_req), 32'h1);
        chk("w1_mem_we", 32'(mem_we), 32'h1);
        chk("w1_mem_addr", 32'(mem_addr), 32'h0040);
        chk("w1_mem_wdata", 32'(mem_wdata), 32'hDEADBEEF);
        step();
        mem_ready = 1'b0; mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        #1 chk("w1_empty", 32'(wb_empty), 32'h1);
        step();

        // Fill with memory stalled, extra request ignored, drain in order.
        for (int i = 0; i < 4; i++) begin
            wr(16'(16'h0100 + i), 32'(32'hA0 + i));
            step();
        end
        wr(16'h01FF, 32'h00000BAD);
        #1 chk("full_up_ready", 32'(up_ready), 32'h0);
        step();
        up_req = 1'b0;
        #1 chk("full_ignored_done", 32'(up_done), 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b1;
            #1;
            chk("order_mem_req", 32'(mem_req), 32'h1);
            chk("order_mem_addr", 32'(mem_addr), 32'(16'h0100 + k));
            chk("order_mem_wdata", 32'(mem_wdata), 32'(32'hA0 + k));
            step();
            mem_ready = 1'b0; mem_done = 1'b1;
            step();
            mem_done = 1'b0;
        end
        #1 chk("order_empty", 32'(wb_empty), 32'h1);
        step();

        // Newest-match forwarding.
        wr(16'h0010, 32'h11); step();
        wr(16'h0010, 32'h22); step();
        rd(16'h0010); step();
        up_req = 1'b0;
        #1;
        chk("fwd_done", 32'(up_done), 32'h1);
        chk("fwd_rdata", 32'(up_rdata), 32'h22);
        chk("fwd_no_pend", 32'(up_ready), 32'h1);
        step();
        drain(40);

        // Read miss bypasses a queued write.
        wr(16'h0020, 32'h5); step();
        rd(16'h0030); step();
        up_req = 1'b0;
        #1 chk("miss_up_ready", 32'(up_ready), 32'h0);
        step();
        mem_ready = 1'b1;
        #1;
        chk("miss_mem_req", 32'(mem_req), 32'h1);
        chk("miss_mem_we", 32'(mem_we), 32'h0);
        chk("miss_mem_addr", 32'(mem_addr), 32'h0030);
        step();
        mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 32'hCAFE0030;
        #1;
        chk("miss_done", 32'(up_done), 32'h1);
        chk("miss_rdata", 32'(up_rdata), 32'hCAFE0030);
        step();
        mem_done = 1'b0;
        drain(40);

        // Read forwarding from the head in its pop cycle.
        mem_ready = 1'b1;
        wr(16'h0055, 32'h99); step();
        up_req = 1'b0; step();
        mem_ready = 1'b0; mem_done = 1'b1;
        rd(16'h0055); step();
        up_req = 1'b0; mem_done = 1'b0;
        #1;
        chk("popfwd_done", 32'(up_done), 32'h1);
        chk("popfwd_rdata", 32'(up_rdata), 32'h99);
        chk("popfwd_empty", 32'(wb_empty), 32'h1);
        step();

        // Push and pop in one cycle with tail wrap.
        rst = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(16'(16'h0200 + i), 32'(32'hB0 + i));
            step();
        end
        up_req = 1'b0; mem_ready = 1'b1; step();
        mem_ready = 1'b0; mem_done = 1'b1;
        wr(16'h0203, 32'hB3); step();
        mem_done = 1'b0;
        wr(16'h0204, 32'hB4);
        #1 chk("wrap_ready_cnt3", 32'(up_ready), 32'h1);
        step();
        up_req = 1'b0;
        #1 chk("wrap_full", 32'(up_ready), 32'h0);
        step();
        for (int k = 1; k < 5; k++) begin
            mem_ready = 1'b1;
            #1;
            chk("wrap_mem_addr", 32'(mem_addr), 32'(16'h0200 + k));
            chk("wrap_mem_wdata", 32'(mem_wdata), 32'(32'hB0 + k));
            step();
            mem_ready = 1'b0; mem_done = 1'b1;
            step();
            mem_done = 1'b0;
        end

        // Reset during an outstanding memory read.
        mem_ready = 1'b1;
        rd(16'h0077); step();
        up_req = 1'b0;
        #1;
        chk("rstrd_mem_req", 32'(mem_req), 32'h1);
        chk("rstrd_mem_addr", 32'(mem_addr), 32'h0077);
        step();
        mem_ready = 1'b0; rst = 1'b1;
        #1;
        chk("rstrd_in_rst_ready", 32'(up_ready), 32'h0);
        chk("rstrd_in_rst_empty", 32'(wb_empty), 32'h1);
        step();
        rst = 1'b0; mem_done = 1'b1; mem_rdata = 32'h12345678;
        #1;
        chk("rstrd_late_done", 32'(up_done), 32'h0);
        chk("rstrd_ready", 32'(up_ready), 32'h1);
        step();
        mem_done = 1'b0;
        step();

        // Randomized traffic with small address space for frequent hits.
        auto_mem = 1'b1; stray_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 249) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            up_req    = ($urandom_range(0, 2) != 0);
            up_we     = $urandom_range(0, 1) == 1;
            up_addr   = AW'($urandom_range(0, 7));
            up_wdata  = $urandom;
            step();
        end
        rst = 1'b0; stray_en = 1'b0;
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
